// File: rtl/econet_hdlc_serializer_pkg.sv
// Shared constants and state encoding for the Econet HDLC transmit serializer.
package econet_hdlc_serializer_pkg;

  localparam logic [7:0] ECO_FLAG        = 8'h7E;
  localparam logic [2:0] ECO_STUFF_LIMIT = 3'd5;

  typedef enum logic [1:0] {
    ECO_IDLE       = 2'd0,
    ECO_OPEN_FLAG  = 2'd1,
    ECO_DATA       = 2'd2,
    ECO_CLOSE_FLAG = 2'd3
  } eco_state_e;

endpackage

// File: rtl/econet_zero_insert.sv
// HDLC zero insertion: counts consecutive data 1s and flags a stuff period after five.
module econet_zero_insert
  import econet_hdlc_serializer_pkg::*;
(
  input  logic econet_clk,
  input  logic reset,
  input  logic line_bit,
  input  logic enable,
  input  logic clear,
  output logic stuff,
  output logic out_bit
);

  logic [2:0] ones_cnt;

  assign stuff   = (ones_cnt == ECO_STUFF_LIMIT);
  assign out_bit = line_bit & ~stuff;

  // A stuffed 0 is a real line 0, so it restarts the run just like a data 0.
  always_ff @(negedge econet_clk) begin
    if (reset || clear) begin
      ones_cnt <= '0;
    end else if (enable) begin
      if (stuff || !line_bit) ones_cnt <= '0;
      else                    ones_cnt <= ones_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/econet_hdlc_serializer.sv
// Econet transmit serializer: opening flag(s), zero-inserted bytes LSB first, closing flag(s).
module econet_hdlc_serializer
  import econet_hdlc_serializer_pkg::*;
#(
  parameter int   OPEN_FLAGS  = 1,
  parameter int   CLOSE_FLAGS = 1,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic       econet_clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       start_frame,
  input  logic       end_frame,
  output logic       request_byte,
  output logic       econet_data,
  output logic       transmitting,
  output eco_state_e dbg_state
);

  localparam int MAX_FLAGS = (OPEN_FLAGS > CLOSE_FLAGS) ? OPEN_FLAGS : CLOSE_FLAGS;
  localparam int FLAG_W    = $clog2(MAX_FLAGS + 1);

  eco_state_e        state, state_n;
  logic [7:0]        shift_reg, shift_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [FLAG_W-1:0] flag_cnt, flag_n;
  logic              data_n, tx_n, req_n;
  logic              zi_bit, zi_en, zi_clear, zi_stuff, zi_out;

  econet_zero_insert u_zero_insert (
    .econet_clk (econet_clk),
    .reset      (reset),
    .line_bit   (zi_bit),
    .enable     (zi_en),
    .clear      (zi_clear),
    .stuff      (zi_stuff),
    .out_bit    (zi_out)
  );

  assign dbg_state = state;

  // shift_reg[0] is always the bit currently on the line; bit_cnt is its index.
  always_comb begin
    state_n  = state;
    shift_n  = shift_reg;
    bit_n    = bit_cnt;
    flag_n   = flag_cnt;
    data_n   = econet_data;
    tx_n     = transmitting;
    req_n    = 1'b0;
    zi_bit   = 1'b0;
    zi_en    = 1'b0;
    zi_clear = 1'b1;
    case (state)
      ECO_IDLE: begin
        data_n = IDLE_LEVEL;
        tx_n   = 1'b0;
        if (start_frame) begin
          state_n = ECO_OPEN_FLAG;
          shift_n = ECO_FLAG;
          data_n  = ECO_FLAG[0];
          bit_n   = '0;
          flag_n  = '0;
          tx_n    = 1'b1;
        end
      end
      ECO_OPEN_FLAG, ECO_DATA: begin
        zi_clear = (state != ECO_DATA);
        if (state == ECO_DATA && zi_stuff) begin
          // Stall one period for the inserted 0; this also defers a byte-boundary load.
          zi_en  = 1'b1;
          data_n = zi_out;
        end else if (bit_cnt == 3'd7) begin
          bit_n = '0;
          if (state == ECO_OPEN_FLAG && flag_cnt != FLAG_W'(OPEN_FLAGS - 1)) begin
            flag_n  = flag_cnt + FLAG_W'(1);
            shift_n = ECO_FLAG;
            data_n  = ECO_FLAG[0];
          end else begin
            req_n = 1'b1;
            if (end_frame) begin
              state_n  = ECO_CLOSE_FLAG;
              shift_n  = ECO_FLAG;
              data_n   = ECO_FLAG[0];
              flag_n   = '0;
              zi_clear = 1'b1;
            end else begin
              state_n  = ECO_DATA;
              shift_n  = tx_byte;
              zi_bit   = tx_byte[0];
              zi_en    = 1'b1;
              zi_clear = 1'b0;
              data_n   = zi_out;
            end
          end
        end else begin
          shift_n = shift_reg >> 1;
          bit_n   = bit_cnt + 3'd1;
          if (state == ECO_DATA) begin
            zi_bit = shift_reg[1];
            zi_en  = 1'b1;
            data_n = zi_out;
          end else begin
            data_n = shift_reg[1];
          end
        end
      end
      ECO_CLOSE_FLAG: begin
        if (bit_cnt == 3'd7) begin
          bit_n = '0;
          if (flag_cnt == FLAG_W'(CLOSE_FLAGS - 1)) begin
            state_n = ECO_IDLE;
            data_n  = IDLE_LEVEL;
            tx_n    = 1'b0;
          end else begin
            flag_n  = flag_cnt + FLAG_W'(1);
            shift_n = ECO_FLAG;
            data_n  = ECO_FLAG[0];
          end
        end else begin
          shift_n = shift_reg >> 1;
          bit_n   = bit_cnt + 3'd1;
          data_n  = shift_reg[1];
        end
      end
      default: state_n = ECO_IDLE;
    endcase
  end

  always_ff @(negedge econet_clk) begin
    if (reset) begin
      state        <= ECO_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      flag_cnt     <= '0;
      econet_data  <= IDLE_LEVEL;
      transmitting <= 1'b0;
      request_byte <= 1'b0;
    end else begin
      state        <= state_n;
      shift_reg    <= shift_n;
      bit_cnt      <= bit_n;
      flag_cnt     <= flag_n;
      econet_data  <= data_n;
      transmitting <= tx_n;
      request_byte <= req_n;
    end
  end

endmodule

// File: tb/tb_econet_hdlc_serializer.sv
// Bench for econet_hdlc_serializer: line bits and request pulses checked against a frame-level model.
module tb_econet_hdlc_serializer;
  import econet_hdlc_serializer_pkg::*;

  localparam int OPEN_FLAGS  = 1;
  localparam int CLOSE_FLAGS = 1;

  logic       econet_clk = 1'b0;
  logic       reset;
  logic [7:0] tx_byte;
  logic       start_frame;
  logic       end_frame;
  logic       request_byte;
  logic       econet_data;
  logic       transmitting;
  eco_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_q[$];
  logic       exp_bits[$];
  logic       exp_req[$];

  always #5 econet_clk = ~econet_clk;

  econet_hdlc_serializer #(
    .OPEN_FLAGS  (OPEN_FLAGS),
    .CLOSE_FLAGS (CLOSE_FLAGS),
    .IDLE_LEVEL  (1'b1)
  ) dut (
    .econet_clk   (econet_clk),
    .reset        (reset),
    .tx_byte      (tx_byte),
    .start_frame  (start_frame),
    .end_frame    (end_frame),
    .request_byte (request_byte),
    .econet_data  (econet_data),
    .transmitting (transmitting),
    .dbg_state    (dbg_state)
  );

  // Expected line: flags, then the whole payload bit stream with a 0 after every five 1s, then flags.
  // A request marks the first real bit of each byte and the first closing-flag bit.
  task automatic build_model();
    logic [7:0] flag;
    int ones;
    flag = 8'h7E;
    ones = 0;
    exp_bits.delete();
    exp_req.delete();
    for (int f = 0; f < OPEN_FLAGS; f++)
      for (int i = 0; i < 8; i++) begin
        exp_bits.push_back(flag[i]);
        exp_req.push_back(1'b0);
      end
    foreach (frame_q[b])
      for (int i = 0; i < 8; i++) begin
        if (ones == 5) begin
          exp_bits.push_back(1'b0);
          exp_req.push_back(1'b0);
          ones = 0;
        end
        exp_bits.push_back(frame_q[b][i]);
        exp_req.push_back(i == 0);
        ones = frame_q[b][i] ? ones + 1 : 0;
      end
    if (ones == 5) begin
      exp_bits.push_back(1'b0);
      exp_req.push_back(1'b0);
    end
    for (int f = 0; f < CLOSE_FLAGS; f++)
      for (int i = 0; i < 8; i++) begin
        exp_bits.push_back(flag[i]);
        exp_req.push_back(f == 0 && i == 0);
      end
  endtask

  // Plays frame_q through the DUT acting as upstream, comparing every bit period plus trailing idle.
  task automatic run_frame(input string name, input int inject_at);
    int idx, n, len;
    logic ed, et, er;
    idx = 0;
    n   = frame_q.size();
    build_model();
    len = exp_bits.size();
    tx_byte     = (n > 0) ? frame_q[0] : 8'($urandom);
    end_frame   = (n == 0);
    start_frame = 1'b1;
    @(posedge econet_clk);
    start_frame = 1'b0;
    for (int k = 0; k < len + 3; k++) begin
      ed = (k < len) ? exp_bits[k] : 1'b1;
      et = (k < len);
      er = (k < len) ? exp_req[k] : 1'b0;
      checks++;
      if (econet_data !== ed) begin
        errors++;
        $display("FAIL %s data bit %0d: got %b expected %b", name, k, econet_data, ed);
      end
      checks++;
      if (transmitting !== et) begin
        errors++;
        $display("FAIL %s transmitting bit %0d: got %b expected %b", name, k, transmitting, et);
      end
      checks++;
      if (request_byte !== er) begin
        errors++;
        $display("FAIL %s request_byte bit %0d: got %b expected %b", name, k, request_byte, er);
      end
      if (request_byte === 1'b1) begin
        idx++;
        tx_byte   = (idx < n) ? frame_q[idx] : 8'($urandom);
        end_frame = (idx >= n);
      end
      start_frame = (k == inject_at);
      @(posedge econet_clk);
    end
    start_frame = 1'b0;
    end_frame   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge econet_clk);
    checks++;
    if (econet_data !== 1'b1 || transmitting !== 1'b0 || request_byte !== 1'b0) begin
      errors++;
      $display("FAIL reset_power_on: got data=%b tx=%b req=%b expected 1 0 0",
               econet_data, transmitting, request_byte);
    end
    reset = 1'b0;
    repeat (4) @(posedge econet_clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge econet_clk);
      checks++;
      if (econet_data !== 1'b1 || transmitting !== 1'b0 || request_byte !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got data=%b tx=%b req=%b expected 1 0 0",
                 i, econet_data, transmitting, request_byte);
      end
    end
    reset = 1'b0;
    @(posedge econet_clk);
  endtask

  task automatic test_basic();
    frame_q = '{8'h01};
    run_frame("basic_01", -1);
  endtask

  task automatic test_stuff_ff();
    frame_q = '{8'hFF};
    run_frame("stuff_ff", -1);
    frame_q = '{8'hF8, 8'h07};
    run_frame("stuff_at_boundary", -1);
  endtask

  task automatic test_straddle();
    frame_q = '{8'hF0, 8'h0F};
    run_frame("straddle", -1);
  endtask

  task automatic test_reset_mid_frame();
    tx_byte     = 8'($urandom);
    end_frame   = 1'b0;
    start_frame = 1'b1;
    @(posedge econet_clk);
    start_frame = 1'b0;
    repeat (12) @(posedge econet_clk);
    reset = 1'b1;
    @(posedge econet_clk);
    checks++;
    if (econet_data !== 1'b1 || transmitting !== 1'b0 || request_byte !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: got data=%b tx=%b req=%b expected 1 0 0",
               econet_data, transmitting, request_byte);
    end
    reset = 1'b0;
    repeat (2) @(posedge econet_clk);
    checks++;
    if (econet_data !== 1'b1 || transmitting !== 1'b0 || request_byte !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: got data=%b tx=%b req=%b expected 1 0 0",
               econet_data, transmitting, request_byte);
    end
    frame_q = '{8'($urandom), 8'($urandom)};
    run_frame("clean_after_reset", -1);
  endtask

  task automatic test_mid_start_and_empty();
    frame_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame("start_during_data", 14);
    frame_q.delete();
    run_frame("empty_frame", -1);
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 10; f++) begin
      frame_q.delete();
      n = $urandom_range(1, 5);
      for (int b = 0; b < n; b++) begin
        case ($urandom_range(0, 2))
          0:       frame_q.push_back(8'($urandom));
          1:       frame_q.push_back(8'hFF);
          default: frame_q.push_back(8'($urandom) | 8'($urandom));
        endcase
      end
      run_frame("random", -1);
    end
  endtask

  task automatic test_back_to_back();
    frame_q = '{8'h7E, 8'h3F};
    run_frame("back_to_back_a", -1);
    frame_q = '{8'hFF, 8'hFF, 8'hFF};
    run_frame("back_to_back_b", -1);
  endtask

  initial begin
    reset       = 1'b1;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    tx_byte     = 8'h00;
    test_reset();
    test_basic();
    test_stuff_ff();
    test_straddle();
    test_reset_mid_frame();
    test_mid_start_and_empty();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
